imem_loader: RTL

Writer side of the instruction-memory interface. The datapath only reads instruction memory, by a 5-bit PC address. This block fills that memory before execution.
- Accepts a program as a byte stream over a valid/ready handshake.
- Assembles big-endian 32-bit words and writes them to consecutive instruction-memory addresses.
- Holds the processor while loading.

---
 rtl/imem_loader_pkg.sv | 15 +
 rtl/byte_assembler.sv | 43 ++++
 rtl/imem_loader.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader: FSM states and word/byte geometry.
package imem_loader_pkg;

    localparam int unsigned BYTE_WIDTH     = 8;
    localparam int unsigned BYTES_PER_WORD = 4;
    localparam int unsigned WORD_WIDTH     = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RECV  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/byte_assembler.sv
// Big-endian byte-to-word shift register with a byte counter that wraps every four bytes.
module byte_assembler
    import imem_loader_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  shiftEn,
    input  logic [BYTE_WIDTH-1:0] byteData,
    output logic [WORD_WIDTH-1:0] word,
    output logic                  wordComplete
);

    logic [WORD_WIDTH-1:0] shift_q, shift_d;
    logic [1:0]            cnt_q, cnt_d;

    always_comb begin
        shift_d = shift_q;
        cnt_d   = cnt_q;
        if (clear) begin
            shift_d = '0;
            cnt_d   = '0;
        end else if (shiftEn) begin
            shift_d = {shift_q[WORD_WIDTH-BYTE_WIDTH-1:0], byteData};
            cnt_d   = cnt_q + 2'd1;
        end
    end

    // Exposes the post-shift value so the 4th byte lands in the word on the same edge it is accepted.
    assign word         = shift_d;
    assign wordComplete = shiftEn && !clear && (cnt_q == 2'(BYTES_PER_WORD - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_q <= '0;
            cnt_q   <= '0;
        end else begin
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Loads a byte-streamed program into instruction memory one big-endian word at a time,
// holding the processor until the last word has been written.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned DEPTH      = 2 ** ADDR_WIDTH
) (
    input  logic                  CLK,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH:0]   wordCount,
    input  logic                  byteValid,
    input  logic [BYTE_WIDTH-1:0] byteData,
    output logic                  byteReady,
    output logic                  writeEnable,
    output logic [ADDR_WIDTH-1:0] writeAddress,
    output logic [WORD_WIDTH-1:0] writeData,
    output logic                  cpuHold,
    output logic                  busy,
    output logic                  done,
    output logic                  error
);

    localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] ONE_W   = (ADDR_WIDTH + 1)'(1);

    state_e                state_q, state_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic [ADDR_WIDTH-1:0] idx_q, idx_d;
    logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
    logic [WORD_WIDTH-1:0] wdata_q, wdata_d;
    logic                  rdy_q, rdy_d;
    logic                  we_q, we_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;

    logic                  xfer;
    logic                  clear;
    logic                  word_complete;
    logic [WORD_WIDTH-1:0] asm_word;
    logic [ADDR_WIDTH:0]   next_idx_ext;

    assign xfer         = byteValid && rdy_q;
    assign next_idx_ext = {1'b0, idx_q} + ONE_W;

    byte_assembler u_asm (
        .clk          (CLK),
        .rst          (reset),
        .clear        (clear),
        .shiftEn      (xfer),
        .byteData     (byteData),
        .word         (asm_word),
        .wordComplete (word_complete)
    );

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        idx_d   = idx_q;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        err_d   = err_q;
        clear   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (wordCount == '0 || wordCount > DEPTH_W) begin
                        err_d = 1'b1;
                    end else begin
                        err_d   = 1'b0;
                        count_d = wordCount;
                        idx_d   = '0;
                        clear   = 1'b1;
                        state_d = RECV;
                    end
                end
            end
            RECV: begin
                if (word_complete) begin
                    waddr_d = idx_q;
                    wdata_d = asm_word;
                    state_d = WRITE;
                end
            end
            WRITE: begin
                // Compare one bit wider than the index so a full-depth load terminates.
                if (next_idx_ext == count_q) begin
                    state_d = DONE;
                end else begin
                    idx_d   = next_idx_ext[ADDR_WIDTH-1:0];
                    state_d = RECV;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        rdy_d  = (state_d == RECV);
        we_d   = (state_d == WRITE);
        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            count_q <= '0;
            idx_q   <= '0;
            waddr_q <= '0;
            wdata_q <= '0;
            rdy_q   <= 1'b0;
            we_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            idx_q   <= idx_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            rdy_q   <= rdy_d;
            we_q    <= we_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign byteReady    = rdy_q;
    assign writeEnable  = we_q;
    assign writeAddress = waddr_q;
    assign writeData    = wdata_q;
    assign cpuHold      = busy_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign error        = err_q;

endmodule
